// File: rtl/adder_controller.sv
// adder_controller
// Sequencing FSM for a four-operand adder datapath. A start in IDLE latches
// the operand-count mode and steps the datapath through load, add and
// result-capture phases, then pulses done for one cycle.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          request a new summation (accepted only in IDLE)
//   mode[1:0]      00 = A+B, 01 = A+B+C, 10/11 = A+B+C+D
//   abort          cancel the sequence in progress (ignored in IDLE)
//   aload..dload   operand register load strobes
//   asel           A-path select
//   bsel[1:0]      accumulate select (00 A+B, 01 +C, 10 +D, 11 no-op)
//   output_enable  result register strobe
//   busy           high in every state except IDLE
//   done           one-cycle pulse, datapath result valid
//   aborted        one-cycle pulse, sequence cancelled
//   overrun        sticky, start seen while busy; cleared on accepted start
//   op_count[7:0]  completed summations, wraps at 255
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | capture all four operands
// ADD_AB | acc = A + B
// ADD_C  | acc += C
// ADD_D  | acc += D
// OUT    | capture acc into the result register
// DONE   | result valid, back to IDLE next cycle
module adder_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] mode,
   input  logic       abort,
   output logic       aload,
   output logic       bload,
   output logic       cload,
   output logic       dload,
   output logic       asel,
   output logic [1:0] bsel,
   output logic       output_enable,
   output logic       busy,
   output logic       done,
   output logic       aborted,
   output logic       overrun,
   output logic [7:0] op_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ADD_AB,
      S_ADD_C,
      S_ADD_D,
      S_OUT,
      S_DONE
   } state_t;

   state_t     state;
   state_t     nxt;
   logic [1:0] mode_q;

   // Normal sequencing; the step count comes from the latched mode only.
   always_comb begin
      nxt = state;
      if (state == S_IDLE) begin
         if (start) nxt = S_LOAD;
      end else if (abort) begin
         nxt = S_IDLE;
      end else begin
         unique case (state)
            S_LOAD:   nxt = S_ADD_AB;
            S_ADD_AB: nxt = (mode_q == 2'b00) ? S_OUT : S_ADD_C;
            S_ADD_C:  nxt = (mode_q == 2'b01) ? S_OUT : S_ADD_D;
            S_ADD_D:  nxt = S_OUT;
            S_OUT:    nxt = S_DONE;
            default:  nxt = S_IDLE;
         endcase
      end
   end

   // Outputs are registered alongside the state by decoding the next state,
   // so each output is a pure function of the state register's new value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         mode_q        <= 2'b00;
         aload         <= 1'b0;
         bload         <= 1'b0;
         cload         <= 1'b0;
         dload         <= 1'b0;
         asel          <= 1'b0;
         bsel          <= 2'b11;
         output_enable <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         aborted       <= 1'b0;
         overrun       <= 1'b0;
         op_count      <= 8'd0;
      end else begin
         state <= nxt;

         if (state == S_IDLE && start) begin
            mode_q  <= mode;
            overrun <= 1'b0;
         end else if (state != S_IDLE && start) begin
            overrun <= 1'b1;
         end

         aborted <= (state != S_IDLE) && abort;

         // Only OUT can reach DONE, so this is exactly "on entry to DONE".
         if (nxt == S_DONE) op_count <= op_count + 8'd1;

         aload         <= (nxt == S_LOAD);
         bload         <= (nxt == S_LOAD);
         cload         <= (nxt == S_LOAD);
         dload         <= (nxt == S_LOAD);
         asel          <= (nxt == S_ADD_AB);
         output_enable <= (nxt == S_OUT);
         busy          <= (nxt != S_IDLE);
         done          <= (nxt == S_DONE);
         unique case (nxt)
            S_ADD_AB: bsel <= 2'b00;
            S_ADD_C:  bsel <= 2'b01;
            S_ADD_D:  bsel <= 2'b10;
            default:  bsel <= 2'b11;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_controller.sv
module tb_adder_controller;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [1:0] mode;
   logic       abort;
   logic       aload, bload, cload, dload;
   logic       asel;
   logic [1:0] bsel;
   logic       output_enable;
   logic       busy, done, aborted, overrun;
   logic [7:0] op_count;

   adder_controller dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .mode          (mode),
      .abort         (abort),
      .aload         (aload),
      .bload         (bload),
      .cload         (cload),
      .dload         (dload),
      .asel          (asel),
      .bsel          (bsel),
      .output_enable (output_enable),
      .busy          (busy),
      .done          (done),
      .aborted       (aborted),
      .overrun       (overrun),
      .op_count      (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nerr = 0;
   int nchk = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: expected per-cycle control trace of the running sequence.
   typedef struct packed {
      logic       ld;
      logic       asel;
      logic [1:0] bsel;
      logic       oe;
      logic       dn;
   } ctl_t;

   localparam ctl_t C_IDLE = '{ld: 1'b0, asel: 1'b0, bsel: 2'b11, oe: 1'b0, dn: 1'b0};

   ctl_t       q[$];
   logic       m_ab;
   logic       m_ov;
   logic [7:0] m_cnt;
   logic       m_busy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_ab  = 1'b0;
         m_ov  = 1'b0;
         m_cnt = 8'd0;
      end else begin
         m_busy = (q.size() != 0);
         m_ab   = 1'b0;
         if (m_busy && start) m_ov = 1'b1;
         else if (!m_busy && start) m_ov = 1'b0;
         if (m_busy && abort) begin
            q.delete();
            m_ab = 1'b1;
         end else if (m_busy) begin
            void'(q.pop_front());
            if (q.size() != 0 && q[0].dn) m_cnt = m_cnt + 8'd1;
         end else if (start) begin
            q.push_back('{ld: 1'b1, asel: 1'b0, bsel: 2'b11, oe: 1'b0, dn: 1'b0});
            q.push_back('{ld: 1'b0, asel: 1'b1, bsel: 2'b00, oe: 1'b0, dn: 1'b0});
            if (mode >= 2'd1) q.push_back('{ld: 1'b0, asel: 1'b0, bsel: 2'b01, oe: 1'b0, dn: 1'b0});
            if (mode >= 2'd2) q.push_back('{ld: 1'b0, asel: 1'b0, bsel: 2'b10, oe: 1'b0, dn: 1'b0});
            q.push_back('{ld: 1'b0, asel: 1'b0, bsel: 2'b11, oe: 1'b1, dn: 1'b0});
            q.push_back('{ld: 1'b0, asel: 1'b0, bsel: 2'b11, oe: 1'b0, dn: 1'b1});
         end
      end
   end

   // Datapath attached to the controls, and the per-cycle compare.
   logic [7:0] op_a, op_b, op_c, op_d;
   logic [7:0] ra, rb, rc, rd, acc, sum;
   ctl_t       e;

   always @(negedge clk) begin
      e = (q.size() != 0) ? q[0] : C_IDLE;
      check("outputs",
            {12'd0, aload, bload, cload, dload, asel, bsel, output_enable,
             done, busy, aborted, overrun, op_count},
            {12'd0, e.ld, e.ld, e.ld, e.ld, e.asel, e.bsel, e.oe,
             e.dn, 1'b0 | (q.size() != 0), m_ab, m_ov, m_cnt});
      check("exclusive",
            32'(($countones({aload, bsel != 2'b11, output_enable}) <= 1)), 32'd1);
      if (aload) begin ra = op_a; rb = op_b; rc = op_c; rd = op_d; end
      if (asel && bsel == 2'b00) acc = ra + rb;
      else if (bsel == 2'b01) acc = acc + rc;
      else if (bsel == 2'b10) acc = acc + rd;
      if (output_enable) sum = acc;
   end

   task automatic run_seq(input logic [1:0] m, input int exp_done, input int ab_cyc,
                          input int st_cyc, input logic [7:0] exp_sum, input logic [7:0] exp_cnt);
      int dc = 0;
      start = 1'b1;
      mode  = m;
      @(posedge clk); #2;
      start = 1'b0;
      mode  = ~m;
      for (int c = 1; c <= 8; c++) begin
         abort = (c == ab_cyc);
         start = (c == st_cyc);
         @(negedge clk); #1;
         if (c == 1) check("ov_clear", overrun, 0);
         if (done) begin
            dc = c;
            check("sum", sum, exp_sum);
         end
         if (ab_cyc != 0 && c == ab_cyc + 1) begin
            check("aborted", aborted, 1);
            check("abort_idle", busy, 0);
         end
         if (st_cyc != 0 && c == st_cyc + 1) check("overrun", overrun, 1);
         @(posedge clk); #2;
      end
      abort = 1'b0;
      start = 1'b0;
      check("done_cycle", dc, exp_done);
      check("op_count", op_count, exp_cnt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   int ndone;
   int last_done;
   int cyc;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 2'b00;
      abort = 1'b0;
      op_a = 8'd3; op_b = 8'd4; op_c = 8'd5; op_d = 8'd6;
      ra = 0; rb = 0; rc = 0; rd = 0; acc = 0; sum = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("rst_busy", busy, 0);
      check("rst_bsel", bsel, 2'b11);
      check("rst_count", op_count, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;

      run_seq(2'b10, 6, 0, 0, 8'd18, 8'd1);
      op_a = 8'd15; op_b = 8'd15;
      run_seq(2'b00, 4, 0, 0, 8'd30, 8'd2);
      op_c = 8'd1;
      run_seq(2'b01, 5, 0, 0, 8'd31, 8'd3);
      run_seq(2'b11, 6, 0, 0, 8'd37, 8'd4);
      run_seq(2'b10, 0, 3, 0, 8'd0, 8'd4);
      run_seq(2'b10, 6, 0, 2, 8'd37, 8'd5);
      check("ov_sticky", overrun, 1);
      run_seq(2'b00, 4, 0, 0, 8'd30, 8'd6);

      abort = 1'b1;
      repeat (2) begin
         @(negedge clk); #1;
         check("idle_abort_busy", busy, 0);
         check("idle_abort_pulse", aborted, 0);
         @(posedge clk); #2;
      end
      abort = 1'b0;

      // Held start: 256 back-to-back mode-00 sequences from a fresh reset.
      rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      start = 1'b1;
      mode  = 2'b00;
      ndone = 0;
      last_done = 0;
      cyc = 0;
      while (ndone < 256 && cyc < 1500) begin
         @(negedge clk); #1;
         cyc++;
         if (done) begin
            ndone++;
            if (ndone > 1) check("b2b_interval", cyc - last_done, 5);
            last_done = cyc;
         end
         @(posedge clk); #2;
      end
      check("wrap_done_count", ndone, 256);
      check("wrap_count", op_count, 0);
      start = 1'b0;
      repeat (6) @(posedge clk);
      #2;

      // Reset dropped between edges while in ADD_D.
      start = 1'b1;
      mode  = 2'b10;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("pre_rst_bsel", bsel, 2'b10);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_busy", busy, 0);
      check("async_bsel", bsel, 2'b11);
      check("async_done", done, 0);
      check("async_count", op_count, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      start = 1'b1;
      mode  = 2'b00;
      @(posedge clk); #2;
      start = 1'b0;
      @(negedge clk); #1;
      check("first_start_load", aload, 1);
      check("first_start_busy", busy, 1);
      repeat (6) @(posedge clk);
      #2;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/adder_controller.md
ADDER_CONTROLLER -- requirements
Module: adder_controller

Interface
REQ-001 The module SHALL have these ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a new summation; sampled only in IDLE
- mode  in  2  operand count: 00 = A+B, 01 = A+B+C, 10/11 = A+B+C+D
- abort  in  1  cancel the sequence in progress
- aload, bload, cload, dload  out  1 each  datapath operand-register load strobes
- asel  out  1  datapath A-path select
- bsel  out  2  datapath accumulate select
- output_enable  out  1  datapath result-register strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; the datapath result is valid
- aborted  out  1  one-cycle pulse; the sequence was cancelled
- overrun  out  1  sticky; start was seen while not in IDLE
- op_count  out  8  number of completed summations

Function
REQ-002 The module SHALL be a Moore FSM with states IDLE, LOAD, ADD_AB, ADD_C, ADD_D, OUT, DONE, and every output SHALL be decoded from registered state only.
REQ-003 Each state SHALL drive these datapath controls; any control not listed is 0:
- IDLE and DONE: asel=0, bsel=11 (datapath no-op)
- LOAD: all four loads = 1, asel=0, bsel=11
- ADD_AB: asel=1, bsel=00
- ADD_C: asel=0, bsel=01
- ADD_D: asel=0, bsel=10
- OUT: output_enable=1, asel=0, bsel=11
REQ-004 More than one of {all loads, an add select, output_enable} SHALL never be active in the same cycle.
REQ-005 In IDLE with start=1, the FSM SHALL latch mode into an internal register and go to LOAD.
REQ-006 The remaining sequence SHALL be LOAD -> ADD_AB -> ADD_C -> ADD_D -> OUT -> DONE -> IDLE, with steps taken according to the latched mode:
- mode 00: ADD_AB goes directly to OUT
- mode 01: ADD_C goes directly to OUT
REQ-007 Latency SHALL be fixed: from the clock edge that samples start, done SHALL be high on cycle 4 (mode 00), cycle 5 (mode 01), or cycle 6 (mode 10/11).
REQ-008 done SHALL be high exactly in DONE, for exactly one cycle.
REQ-009 DONE SHALL return to IDLE unconditionally; a start during DONE SHALL be ignored and SHALL set overrun.
REQ-010 Changes to mode after start has been accepted SHALL have no effect on the sequence in progress.
REQ-011 abort=1 in any state other than IDLE SHALL take the FSM to IDLE on the next edge, pulse aborted for one cycle, suppress done, and leave op_count unchanged.
REQ-012 abort has priority over start and over normal sequencing; abort in IDLE SHALL be ignored.
REQ-013 start=1 in any state other than IDLE SHALL set overrun and SHALL NOT alter the sequence.
REQ-014 overrun SHALL be cleared on the edge on which a start is accepted in IDLE.
REQ-015 op_count SHALL increment by 1 on entry to DONE and SHALL wrap from 255 to 0.
REQ-016 A held start SHALL launch a new sequence on the first IDLE cycle after DONE, giving back-to-back operation.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE
- busy, done, aborted, overrun, all loads and output_enable to 0
- asel=0, bsel=11
- op_count=0 and latched mode=00
REQ-018 Reset asserted mid-sequence SHALL abandon the sequence without pulsing done or aborted.
REQ-019 The first start SHALL be sampled on the first rising edge after rst_n deasserts.

Verification
REQ-020 mode=10, start pulse -> state/control trace LOAD, ADD_AB, ADD_C, ADD_D, OUT, DONE; with the datapath attached and A,B,C,D = 3,4,5,6, o_sum=18 when done=1, and op_count=1.
REQ-021 mode=00, A=15, B=15 -> done on cycle 4 with o_sum=30; mode=01 with C=1 -> done on cycle 5 with o_sum=31.
REQ-022 abort asserted in ADD_C -> next cycle state IDLE and aborted=1; no done pulse; op_count unchanged.
REQ-023 start pulsed during ADD_AB -> overrun=1 and the sequence is unchanged; the next accepted start clears overrun.
REQ-024 256 completed mode-00 sequences -> op_count returns to 0; start held high continuously -> done pulses every 5 cycles.
REQ-025 rst_n driven low mid-ADD_D between clock edges -> outputs reach reset values immediately; no done pulse.
